sequence_checker: RTL and testbench
===================================

SEQUENCE_CHECKER -- requirements
Module: sequence_checker

Interface
REQ-001 SHALL provide parameter LOCK_CNT, default 3: consecutive correct samples (including the first) needed to declare lock; legal range 2..15.
REQ-002 SHALL provide parameter UNLOCK_ERRS, default 2: consecutive mismatches in LOCKED that force loss of lock; legal range 1..15.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: in_data is sampled on this edge.
REQ-006 SHALL have port in_data, input, 4 bits: observed sequence value, e.g. a sequence counter output.
REQ-007 SHALL have port locked, output, 1 bit: level; high while in LOCKED.
REQ-008 SHALL have port err, output, 1 bit: one-cycle pulse per mismatched sample in LOCKED.
REQ-009 SHALL have port err_count, output, 8 bits: saturating mismatch total.
REQ-010 SHALL have port exp_data, output, 4 bits: next expected value; 0 when not LOCKED.

Function
REQ-011 SHALL check against the fixed 8-entry cyclic sequence 0,1,3,7,15,14,12,8, then wrap 8->0.
REQ-012 SHALL register all outputs; a sample taken at edge N SHALL be reflected on the outputs immediately after edge N.
REQ-013 SHALL implement states SEARCH, ACQUIRE, LOCKED, plus a 3-bit expected index, a 4-bit good counter and a 4-bit miss counter.
REQ-014 SHALL, when in_valid=0, hold all state and counters, and drive err=0.
REQ-015 SHALL, in SEARCH on a valid sequence member: set index to the successor of that member, set good=1 and go to ACQUIRE; SHALL ignore non-members (5, 9, ...) without asserting err.
REQ-016 SHALL, in ACQUIRE on a sample equal to the expected value: advance the index and increment good; when good reaches LOCK_CNT, SHALL go to LOCKED with miss=0.
REQ-017 SHALL, in ACQUIRE on a mismatch: restart as in REQ-015 if the sample is a member, else go to SEARCH; err SHALL stay 0.
REQ-018 SHALL, in LOCKED on a match: advance the index and clear miss.
REQ-019 SHALL, in LOCKED on a mismatch: pulse err, saturating-increment err_count (255 holds), increment miss and still advance the index (skip semantics).
REQ-020 SHALL leave LOCKED for SEARCH on the mismatch that makes miss equal UNLOCK_ERRS; that mismatch SHALL still pulse err and count.
REQ-021 SHALL drive exp_data with the sequence value at the current index while LOCKED, else 0.
REQ-022 SHALL NOT clear err_count on loss of lock; only reset clears it.

Reset
REQ-023 SHALL, on reset=1 at an edge, force SEARCH, index=0, good=0, miss=0, locked=0, err=0, err_count=0 and exp_data=0, regardless of in_valid.
REQ-024 SHALL give reset priority over a simultaneous valid sample; that sample is discarded.
REQ-025 SHALL apply a reset received mid-LOCKED at that edge; the next valid sample re-enters via REQ-015.

Verification
REQ-026 Scenario: reset held for 2 edges with in_valid=1 and in_data=3 -> locked=0, err=0, err_count=0, exp_data=0.
REQ-027 Scenario: after reset, valid 0,1,3 on consecutive edges -> locked=1 after the third edge, exp_data=7, err never asserted.
REQ-028 Scenario: locked, feed 7,15,5,12 -> single err pulse after the 5, err_count=1, locked stays 1, 12 matches, exp_data=8.
REQ-029 Scenario: locked, feed two consecutive mismatches 9,9 -> err pulses twice, err_count +2, locked=0 after the second; then 0,1,3 relocks.
REQ-030 Scenario: locked, in_valid low for 5 cycles between 3 and 7 -> no err, exp_data stays 7, locked stays 1.
REQ-031 Scenario: 300 mismatches with locks interleaved -> err_count saturates at 255; reset mid-LOCKED -> all outputs 0 after that edge.

Source files
------------

// File: rtl/sequence_checker.sv
// sequence_checker: locks onto the cyclic sequence 0,1,3,7,15,14,12,8 and
// flags/counts mismatched samples while locked. All outputs are registered.
module sequence_checker #(
    parameter int unsigned LOCK_CNT    = 3,
    parameter int unsigned UNLOCK_ERRS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    output logic       locked,
    output logic       err,
    output logic [7:0] err_count,
    output logic [3:0] exp_data
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] good_q, good_d;
    logic [3:0] miss_q, miss_d;

    logic       err_d;
    logic [7:0] err_count_d;
    logic       locked_d;
    logic [3:0] exp_data_d;

    logic       match_c;
    logic       member_c;
    logic [2:0] member_idx_c;

    // Sequence table: value at a given index.
    function automatic logic [3:0] seq_val(input logic [2:0] i);
        logic [3:0] v;
        case (i)
            3'd0:    v = 4'd0;
            3'd1:    v = 4'd1;
            3'd2:    v = 4'd3;
            3'd3:    v = 4'd7;
            3'd4:    v = 4'd15;
            3'd5:    v = 4'd14;
            3'd6:    v = 4'd12;
            default: v = 4'd8;
        endcase
        return v;
    endfunction

    assign match_c = (in_data == seq_val(idx_q));

    // Reverse lookup: is the sample a sequence member, and at which index.
    always_comb begin
        member_c     = 1'b0;
        member_idx_c = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (seq_val(3'(i)) == in_data) begin
                member_c     = 1'b1;
                member_idx_c = 3'(i);
            end
        end
    end

    // State register plus registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= SEARCH;
            idx_q     <= 3'd0;
            good_q    <= 4'd0;
            miss_q    <= 4'd0;
            locked    <= 1'b0;
            err       <= 1'b0;
            err_count <= 8'd0;
            exp_data  <= 4'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            good_q    <= good_d;
            miss_q    <= miss_d;
            locked    <= locked_d;
            err       <= err_d;
            err_count <= err_count_d;
            exp_data  <= exp_data_d;
        end
    end

    // Next-state logic: search, acquire and tracking of the sequence.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        good_d  = good_q;
        miss_d  = miss_q;
        if (in_valid) begin
            case (state_q)
                SEARCH: begin
                    if (member_c) begin
                        idx_d   = member_idx_c + 3'd1;
                        good_d  = 4'd1;
                        state_d = ACQUIRE;
                    end
                end
                ACQUIRE: begin
                    if (match_c) begin
                        idx_d  = idx_q + 3'd1;
                        good_d = good_q + 4'd1;
                        if (good_q + 4'd1 == 4'(LOCK_CNT)) begin
                            state_d = LOCKED;
                            miss_d  = 4'd0;
                        end
                    end else if (member_c) begin
                        // Resynchronise on the new member instead of dropping out.
                        idx_d  = member_idx_c + 3'd1;
                        good_d = 4'd1;
                    end else begin
                        good_d  = 4'd0;
                        state_d = SEARCH;
                    end
                end
                LOCKED: begin
                    // Index advances on every sample, matched or not.
                    idx_d = idx_q + 3'd1;
                    if (match_c) begin
                        miss_d = 4'd0;
                    end else if (miss_q + 4'd1 == 4'(UNLOCK_ERRS)) begin
                        miss_d  = 4'd0;
                        good_d  = 4'd0;
                        state_d = SEARCH;
                    end else begin
                        miss_d = miss_q + 4'd1;
                    end
                end
                default: begin
                    state_d = SEARCH;
                    idx_d   = 3'd0;
                    good_d  = 4'd0;
                    miss_d  = 4'd0;
                end
            endcase
        end
    end

    // Output logic: next values for the registered outputs.
    always_comb begin
        err_d       = in_valid && (state_q == LOCKED) && !match_c;
        err_count_d = err_count;
        if (err_d && (err_count != 8'hFF)) begin
            err_count_d = err_count + 8'd1;
        end
        locked_d   = (state_d == LOCKED);
        exp_data_d = locked_d ? seq_val(idx_d) : 4'd0;
    end

endmodule

// File: tb/tb_sequence_checker.sv
// Directed testbench for sequence_checker with hand-computed expectations.
module tb_sequence_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [3:0] in_data;
    logic       locked;
    logic       err;
    logic [7:0] err_count;
    logic [3:0] exp_data;

    int total = 0;
    int bad   = 0;
    int ec;

    sequence_checker #(.LOCK_CNT(3), .UNLOCK_ERRS(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .locked    (locked),
        .err       (err),
        .err_count (err_count),
        .exp_data  (exp_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic chk_out(input string tag, input int l, input int e, input int c, input int x);
        chk({tag, "_locked"}, int'(locked), l);
        chk({tag, "_err"}, int'(err), e);
        chk({tag, "_cnt"}, int'(err_count), c);
        chk({tag, "_exp"}, int'(exp_data), x);
    endtask

    task automatic step(input logic v, input logic [3:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'd3;

        // Reset held two edges with a valid member on the input
        step(1'b1, 4'd3);
        chk_out("rst1", 0, 0, 0, 0);
        step(1'b1, 4'd3);
        chk_out("rst2", 0, 0, 0, 0);
        reset = 1'b0;

        // Acquire and lock on 0,1,3
        step(1'b1, 4'd0);  chk_out("acq0", 0, 0, 0, 0);
        step(1'b1, 4'd1);  chk_out("acq1", 0, 0, 0, 0);
        step(1'b1, 4'd3);  chk_out("lock", 1, 0, 0, 7);

        // Idle gap while locked holds everything
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'd9);
            chk_out("idle", 1, 0, 0, 7);
        end

        // 7,15,5,12: single skip mismatch
        step(1'b1, 4'd7);  chk_out("m7", 1, 0, 0, 15);
        step(1'b1, 4'd15); chk_out("m15", 1, 0, 0, 14);
        step(1'b1, 4'd5);  chk_out("mis5", 1, 1, 1, 12);
        step(1'b1, 4'd12); chk_out("m12", 1, 0, 1, 8);

        // Two consecutive mismatches drop lock; index wraps 8->0
        step(1'b1, 4'd9);  chk_out("misA", 1, 1, 2, 0);
        step(1'b1, 4'd9);  chk_out("misB", 0, 1, 3, 0);
        step(1'b1, 4'd0);  chk_out("re0", 0, 0, 3, 0);
        step(1'b1, 4'd1);  chk_out("re1", 0, 0, 3, 0);
        step(1'b1, 4'd3);  chk_out("re3", 1, 0, 3, 7);

        // err is a pulse; a match clears the miss counter
        step(1'b1, 4'd5);  chk_out("pulse", 1, 1, 4, 15);
        step(1'b0, 4'd5);  chk_out("pulse_off", 1, 0, 4, 15);
        step(1'b1, 4'd15); chk_out("clr15", 1, 0, 4, 14);
        step(1'b1, 4'd9);  chk_out("miss1a", 1, 1, 5, 12);
        step(1'b1, 4'd12); chk_out("clr12", 1, 0, 5, 8);
        step(1'b1, 4'd9);  chk_out("miss1b", 1, 1, 6, 0);
        step(1'b1, 4'd0);  chk_out("clr0", 1, 0, 6, 1);

        // Unlock, then non-members ignored in SEARCH
        step(1'b1, 4'd9);  chk_out("ul1", 1, 1, 7, 3);
        step(1'b1, 4'd9);  chk_out("ul2", 0, 1, 8, 0);
        step(1'b1, 4'd5);  chk_out("nm5", 0, 0, 8, 0);
        step(1'b1, 4'd9);  chk_out("nm9", 0, 0, 8, 0);

        // ACQUIRE member mismatch restarts from that member
        step(1'b1, 4'd0);  chk_out("rs0", 0, 0, 8, 0);
        step(1'b1, 4'd1);  chk_out("rs1", 0, 0, 8, 0);
        step(1'b1, 4'd7);  chk_out("rs7", 0, 0, 8, 0);
        step(1'b1, 4'd15); chk_out("rs15", 0, 0, 8, 0);
        step(1'b1, 4'd14); chk_out("rs14", 1, 0, 8, 12);

        // 300 mismatches with relocks in between; count saturates at 255
        ec = 8;
        for (int r = 0; r < 150; r++) begin
            step(1'b1, 4'd9);
            if (ec < 255) ec++;
            chk("sat_err1", int'(err), 1);
            step(1'b1, 4'd9);
            if (ec < 255) ec++;
            chk_out("sat_drop", 0, 1, ec, 0);
            step(1'b1, 4'd0);
            step(1'b1, 4'd1);
            step(1'b1, 4'd3);
            chk_out("sat_relock", 1, 0, ec, 7);
        end
        chk("sat_255", int'(err_count), 255);
        step(1'b1, 4'd9);  chk_out("sat_hold", 1, 1, 255, 15);

        // Reset mid-LOCKED with a matching valid sample: sample discarded
        reset = 1'b1;
        step(1'b1, 4'd15); chk_out("rst_lock", 0, 0, 0, 0);
        reset = 1'b0;
        step(1'b1, 4'd15); chk_out("post15", 0, 0, 0, 0);
        step(1'b1, 4'd14); chk_out("post14", 0, 0, 0, 0);
        step(1'b1, 4'd12); chk_out("post12", 1, 0, 0, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
